dispatcher_pp: RTL
==================

Name: dispatcher_pp

Overview:
- Next-generation dispatcher. It reads GFP8 lines from a two-bank (ping-pong) dispatcher BRAM and writes them to NUM_TILES tile BRAMs.
- Two modes: distribute (UGD-vector round-robin over enabled columns) and broadcast.
- Bank-valid tracking lets the fetcher fill one bank while the other is dispatched.
- Sits between the fetcher/dispatcher BRAM pair and the tile array, replacing the single-buffer dispatcher.

Parameters:
- MAN_WIDTH, 256, mantissa line width.
- EXP_WIDTH, 8, exponent width per line.
- NUM_TILES, 24, tile column count, 2..32.
- BANK_DEPTH, 512, lines per bank, power of 2.
- TILE_ADDR_WIDTH, 9, tile BRAM address width.
- LINES_PER_NV, 4, BRAM lines per native vector, power of 2.
- COL_W, $clog2(NUM_TILES), column index width.
- RD_ADDR_WIDTH, $clog2(2*BANK_DEPTH), BRAM read address width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  async active-high reset
- i_disp_en  in  1  command strobe, accepted only when o_disp_ready=1
- i_disp_bank  in  1  source bank
- i_disp_tile_addr  in  TILE_ADDR_WIDTH  tile base address
- i_disp_man_nv_cnt  in  8  total NVs
- i_disp_ugd_vec_size  in  8  NVs per UGD vector
- i_disp_col_en  in  NUM_TILES  column enable mask
- i_disp_col_start  in  COL_W  first distribution column
- i_disp_broadcast  in  1  1=broadcast, 0=distribute
- o_disp_ready  out  1  high in IDLE
- o_disp_done  out  1  one-cycle completion pulse
- o_disp_err  out  1  one-cycle pulse coincident with done on a bad command
- i_bank_fill_done  in  2  fetcher pulse, marks bank b valid
- o_bank_valid  out  2  bank holds undispatched data
- o_bram_rd_en  out  1  BRAM read enable
- o_bram_rd_addr  out  RD_ADDR_WIDTH  bank*BANK_DEPTH + line
- i_bram_man_rd_data  in  MAN_WIDTH  mantissa read data, 1-cycle latency
- i_bram_exp_rd_data  in  EXP_WIDTH  exponent read data, 1-cycle latency
- o_tile_wr_addr  out  TILE_ADDR_WIDTH  tile write address
- o_tile_man_wr_data  out  MAN_WIDTH  mantissa write data
- o_tile_exp_wr_data  out  EXP_WIDTH  exponent write data
- o_tile_wr_en  out  NUM_TILES  per-tile write enable
- o_state  out  3  debug state encoding

Behaviour:
- Reset: all outputs 0 except o_disp_ready=1; state IDLE; o_bank_valid=0. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE(0), WAIT_BANK(1), READ(2), DRAIN(3), DONE(4).
- IDLE: on i_disp_en, latch all command fields. L = nv_cnt*LINES_PER_NV; U = ugd_vec_size*LINES_PER_NV.
  - If nv_cnt=0, or (distribute and (col_en=0 or ugd=0)): go to DONE with err=1; no reads; bank untouched.
  - Otherwise go to WAIT_BANK.
- L>BANK_DEPTH: clamp to BANK_DEPTH lines; err=1 at done; the transfer still runs.
- WAIT_BANK: wait for o_bank_valid[bank]=1, then enter READ next cycle.
- READ: issue one read per cycle, registered, line k=0..L-1. Go to DRAIN after the last issue.
- Pipeline: read at cycle N, data at N+1, registered tile write at N+2. First tile write occurs 2 cycles after READ entry; no bubbles.
- DRAIN: 2 cycles to flush the pipeline. Then clear o_bank_valid[bank] and go to DONE.
- DONE: o_disp_done=1 (plus o_disp_err if flagged) for one cycle, then IDLE. o_disp_ready returns high in the IDLE cycle.
- Bank-valid update: set by i_bank_fill_done[b], cleared by release. If set and clear hit the same bank in the same cycle, set wins.
- Broadcast write: o_tile_wr_en=col_en; o_tile_wr_addr=tile_addr+k.
- Distribute write:
  - Line k belongs to group g=k/U, offset o=k%U.
  - The column pointer starts at the first enabled column at or after col_start, wrapping modulo NUM_TILES. It advances to the next enabled column, with wrap, at each group end.
  - round increments whenever the pointer has visited popcount(col_en) groups since the last increment.
  - o_tile_wr_en is one-hot at the pointer; o_tile_wr_addr = tile_addr + round*U + o.
- Tile address arithmetic is modulo 2^TILE_ADDR_WIDTH (silent wrap).
- col_start >= NUM_TILES is treated as 0.
- A partial last group (L not a multiple of U) is written as-is.
- i_disp_en outside IDLE is ignored.

Test Plan:
- Broadcast: bank0 filled; cmd nv=2, col_en=0x00000F, tile_addr=0x10 -> 8 writes, addr 0x10..0x17, wr_en=0xF, first write 2 cycles after READ entry, done then bank_valid[0]=0.
- Distribute: nv=4, ugd=1, col_en=0b1011, col_start=1 -> columns 1,3,0,1; addrs 0-3,0-3,0-3,4-7 (round increments after 3 groups).
- Ping-pong: dispatch bank0 while i_bank_fill_done[1] pulses mid-READ -> bank_valid[1]=1 kept; next cmd on bank1 skips wait; cmd on bank0 waits in WAIT_BANK until refill.
- Errors: nv=0 -> done+err, no rd_en, no wr_en. nv=200 (L=800>512) -> 512 writes, err at done.
- Wrap/collision: tile_addr=0x1FE, broadcast nv=1 -> addrs 0x1FE, 0x1FF, 0x000, 0x001. fill_done[0] in the release cycle -> bank_valid[0] stays 1.
- Reset asserted mid-READ -> all outputs 0 next edge, ready=1, bank_valid=0, no done.

Source files
------------

// File: rtl/dispatcher_pp.sv
// dispatcher_pp: ping-pong dispatcher. Streams GFP8 lines out of one bank of a
// two-bank dispatcher BRAM and writes them into NUM_TILES tile BRAMs, either
// broadcast to every enabled column or distributed round-robin in UGD-sized
// groups. Per-bank valid flags let the fetcher refill one bank while the other
// bank is being dispatched.
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_disp_*               command (accepted only while o_disp_ready)
//   o_disp_ready/done/err  handshake: ready in IDLE, one-cycle done (+err)
//   i_bank_fill_done       fetcher pulse per bank, sets o_bank_valid[b]
//   o_bank_valid           bank holds undispatched data
//   o_bram_rd_*            dispatcher BRAM read port ({bank, line})
//   i_bram_*_rd_data       BRAM read data, one-cycle latency
//   o_tile_*               tile BRAM write port, per-tile write enables
//   o_state                debug state encoding
module dispatcher_pp #(
    parameter int unsigned MAN_WIDTH       = 256,
    parameter int unsigned EXP_WIDTH       = 8,
    parameter int unsigned NUM_TILES       = 24,
    parameter int unsigned BANK_DEPTH      = 512,
    parameter int unsigned TILE_ADDR_WIDTH = 9,
    parameter int unsigned LINES_PER_NV    = 4,
    parameter int unsigned COL_W           = $clog2(NUM_TILES),
    parameter int unsigned RD_ADDR_WIDTH   = $clog2(2 * BANK_DEPTH)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_disp_en,
    input  logic                       i_disp_bank,
    input  logic [TILE_ADDR_WIDTH-1:0] i_disp_tile_addr,
    input  logic [7:0]                 i_disp_man_nv_cnt,
    input  logic [7:0]                 i_disp_ugd_vec_size,
    input  logic [NUM_TILES-1:0]       i_disp_col_en,
    input  logic [COL_W-1:0]           i_disp_col_start,
    input  logic                       i_disp_broadcast,
    output logic                       o_disp_ready,
    output logic                       o_disp_done,
    output logic                       o_disp_err,
    input  logic [1:0]                 i_bank_fill_done,
    output logic [1:0]                 o_bank_valid,
    output logic                       o_bram_rd_en,
    output logic [RD_ADDR_WIDTH-1:0]   o_bram_rd_addr,
    input  logic [MAN_WIDTH-1:0]       i_bram_man_rd_data,
    input  logic [EXP_WIDTH-1:0]       i_bram_exp_rd_data,
    output logic [TILE_ADDR_WIDTH-1:0] o_tile_wr_addr,
    output logic [MAN_WIDTH-1:0]       o_tile_man_wr_data,
    output logic [EXP_WIDTH-1:0]       o_tile_exp_wr_data,
    output logic [NUM_TILES-1:0]       o_tile_wr_en,
    output logic [2:0]                 o_state
);

    localparam int unsigned LINE_W = $clog2(BANK_DEPTH);
    localparam int unsigned U_W    = 8 + $clog2(LINES_PER_NV);
    localparam int unsigned PC_W   = COL_W + 1;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitBank = 3'd1,
        StRead     = 3'd2,
        StDrain    = 3'd3,
        StDone     = 3'd4
    } state_e;

    // First enabled column at or after start, wrapping; start may equal NUM_TILES.
    function automatic logic [COL_W-1:0] next_col(input logic [NUM_TILES-1:0] mask,
                                                  input logic [PC_W-1:0]      start);
        logic [COL_W-1:0] sel_hi;
        logic [COL_W-1:0] sel_lo;
        logic             hit_hi;
        sel_hi = '0;
        sel_lo = '0;
        hit_hi = 1'b0;
        for (int j = NUM_TILES - 1; j >= 0; j--) begin
            if (mask[j]) begin
                sel_lo = COL_W'(j);
                if (j >= int'(start)) begin
                    sel_hi = COL_W'(j);
                    hit_hi = 1'b1;
                end
            end
        end
        return hit_hi ? sel_hi : sel_lo;
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_TILES-1:0] mask);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            n = n + PC_W'(mask[i]);
        end
        return n;
    endfunction

    state_e state_q, state_d;

    // Latched command
    logic                       bank_q;
    logic [TILE_ADDR_WIDTH-1:0] tile_addr_q;
    logic [LINE_W-1:0]          last_q;
    logic [U_W-1:0]             u_q;
    logic [NUM_TILES-1:0]       col_en_q;
    logic [COL_W-1:0]           col_start_q;
    logic                       bcast_q;
    logic                       err_q;
    logic [PC_W-1:0]            pop_q;

    logic [1:0] bank_valid_q, bank_clr;
    logic       drain_q;

    // Issue-stage counters, describing the line currently being read
    logic                       rd_en_q;
    logic [LINE_W-1:0]          k_q;
    logic [U_W-1:0]             off_q;
    logic [COL_W-1:0]           ptr_q;
    logic [PC_W-1:0]            visited_q;
    logic [TILE_ADDR_WIDTH-1:0] base_q;

    // Metadata stage aligned with the BRAM read data
    logic                       p1_valid_q;
    logic [TILE_ADDR_WIDTH-1:0] p1_addr_q;
    logic [NUM_TILES-1:0]       p1_en_q;

    logic [NUM_TILES-1:0]       wr_en_q;
    logic [TILE_ADDR_WIDTH-1:0] wr_addr_q;
    logic [MAN_WIDTH-1:0]       man_q;
    logic [EXP_WIDTH-1:0]       exp_q;

    // Command decode
    logic [31:0]      cmd_lines;
    logic             cmd_bad;
    logic             cmd_clamp;
    logic [COL_W-1:0] cmd_start;

    always_comb begin
        cmd_lines = 32'(i_disp_man_nv_cnt) * LINES_PER_NV;
        cmd_bad   = (i_disp_man_nv_cnt == 8'd0) ||
                    (!i_disp_broadcast && ((i_disp_col_en == '0) ||
                                           (i_disp_ugd_vec_size == 8'd0)));
        cmd_clamp = cmd_lines > BANK_DEPTH;
        cmd_start = (32'(i_disp_col_start) >= NUM_TILES) ? '0 : i_disp_col_start;
    end

    logic                       last_line;
    logic                       grp_end;
    logic [TILE_ADDR_WIDTH-1:0] cur_addr;
    logic [NUM_TILES-1:0]       cur_en;

    always_comb begin
        last_line = (k_q == last_q);
        grp_end   = (off_q == u_q - U_W'(1));
        if (bcast_q) begin
            cur_addr = tile_addr_q + TILE_ADDR_WIDTH'(k_q);
            cur_en   = col_en_q;
        end else begin
            cur_addr = tile_addr_q + base_q + TILE_ADDR_WIDTH'(off_q);
            cur_en   = NUM_TILES'(1) << ptr_q;
        end
    end

    // FSM next state and release of the dispatched bank
    always_comb begin
        state_d  = state_q;
        bank_clr = 2'b00;
        case (state_q)
            StIdle:     if (i_disp_en) state_d = cmd_bad ? StDone : StWaitBank;
            StWaitBank: if (bank_valid_q[bank_q]) state_d = StRead;
            StRead:     if (last_line) state_d = StDrain;
            StDrain: begin
                if (drain_q) begin
                    state_d          = StDone;
                    bank_clr[bank_q] = 1'b1;
                end
            end
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= StIdle;
            bank_valid_q <= 2'b00;
            drain_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            // A fill landing on the bank being released wins.
            bank_valid_q <= (bank_valid_q & ~bank_clr) | i_bank_fill_done;
            drain_q      <= (state_q == StDrain) ? ~drain_q : 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bank_q      <= 1'b0;
            tile_addr_q <= '0;
            last_q      <= '0;
            u_q         <= '0;
            col_en_q    <= '0;
            col_start_q <= '0;
            bcast_q     <= 1'b0;
            err_q       <= 1'b0;
            pop_q       <= '0;
        end else if (state_q == StIdle && i_disp_en) begin
            bank_q      <= i_disp_bank;
            tile_addr_q <= i_disp_tile_addr;
            last_q      <= cmd_clamp ? LINE_W'(BANK_DEPTH - 1) : LINE_W'(cmd_lines - 32'd1);
            u_q         <= U_W'(i_disp_ugd_vec_size) * U_W'(LINES_PER_NV);
            col_en_q    <= i_disp_col_en;
            col_start_q <= cmd_start;
            bcast_q     <= i_disp_broadcast;
            err_q       <= cmd_bad | cmd_clamp;
            pop_q       <= popcount(i_disp_col_en);
        end
    end

    // Read issue: one line per cycle, column/round bookkeeping advances with it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_en_q   <= 1'b0;
            k_q       <= '0;
            off_q     <= '0;
            ptr_q     <= '0;
            visited_q <= '0;
            base_q    <= '0;
        end else if (state_q == StWaitBank && state_d == StRead) begin
            rd_en_q   <= 1'b1;
            k_q       <= '0;
            off_q     <= '0;
            ptr_q     <= next_col(col_en_q, {1'b0, col_start_q});
            visited_q <= '0;
            base_q    <= '0;
        end else if (state_q == StRead) begin
            if (last_line) begin
                rd_en_q <= 1'b0;
            end else begin
                k_q <= k_q + LINE_W'(1);
                if (grp_end) begin
                    off_q <= '0;
                    ptr_q <= next_col(col_en_q, {1'b0, ptr_q} + PC_W'(1));
                    // A full sweep of the enabled columns opens a new round.
                    if (visited_q + PC_W'(1) == pop_q) begin
                        visited_q <= '0;
                        base_q    <= base_q + TILE_ADDR_WIDTH'(u_q);
                    end else begin
                        visited_q <= visited_q + PC_W'(1);
                    end
                end else begin
                    off_q <= off_q + U_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            p1_valid_q <= 1'b0;
            p1_addr_q  <= '0;
            p1_en_q    <= '0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            man_q      <= '0;
            exp_q      <= '0;
        end else begin
            p1_valid_q <= rd_en_q;
            p1_addr_q  <= cur_addr;
            p1_en_q    <= cur_en;
            wr_en_q    <= p1_valid_q ? p1_en_q : '0;
            wr_addr_q  <= p1_valid_q ? p1_addr_q : '0;
            man_q      <= p1_valid_q ? i_bram_man_rd_data : '0;
            exp_q      <= p1_valid_q ? i_bram_exp_rd_data : '0;
        end
    end

    assign o_disp_ready       = (state_q == StIdle);
    assign o_disp_done        = (state_q == StDone);
    assign o_disp_err         = (state_q == StDone) && err_q;
    assign o_bank_valid       = bank_valid_q;
    assign o_bram_rd_en       = rd_en_q;
    assign o_bram_rd_addr     = rd_en_q ? RD_ADDR_WIDTH'({bank_q, k_q}) : '0;
    assign o_tile_wr_en       = wr_en_q;
    assign o_tile_wr_addr     = wr_addr_q;
    assign o_tile_man_wr_data = man_q;
    assign o_tile_exp_wr_data = exp_q;
    assign o_state            = state_q;

endmodule
